// File: rtl/window_monitor_pkg.sv
// Shared definitions for the window monitor: FSM encoding and the window
// constants agreed with the upstream phase-counter stage.
package window_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OPEN   = 2'd1,
        REPORT = 2'd2,
        DRAIN  = 2'd3
    } mon_state_t;

    localparam int WIN_EXP_LEN = 2;
    localparam int WIN_MAX_LEN = 7;

endpackage

// File: rtl/window_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module window_monitor_sat_counter #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/window_monitor.sv
// Measures width and opening phase of each upstream window and reports them
// over a valid/ready interface, with completed-window count and sticky flags.
module window_monitor
    import window_monitor_pkg::*;
#(
    parameter int CNT_W   = 3,
    parameter int LEN_W   = 4,
    parameter int NUM_W   = 8,
    parameter int EXP_LEN = WIN_EXP_LEN,
    parameter int MAX_LEN = WIN_MAX_LEN
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             en,
    input  logic             clr,
    input  logic             win_in,
    input  logic [CNT_W-1:0] cyc_cnt,
    input  logic             rpt_ready,
    output logic             rpt_valid,
    output logic [LEN_W-1:0] rpt_len,
    output logic [CNT_W-1:0] rpt_start,
    output logic             rpt_err,
    output logic [NUM_W-1:0] win_count,
    output logic             err_sticky,
    output logic             ovr_sticky
);

    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] EXP_L = LEN_W'(EXP_LEN);

    mon_state_t       state_reg, state_next;
    logic             win_d_reg;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [CNT_W-1:0] start_reg, start_next;
    logic [LEN_W-1:0] rpt_len_reg, rpt_len_next;
    logic             rpt_err_reg, rpt_err_next;
    logic             to_pend_reg, to_pend_next;
    logic             err_sticky_reg, ovr_sticky_reg;
    logic             arm, hs, drop;

    assign arm = win_in & ~win_d_reg & en;
    assign hs  = rpt_valid & rpt_ready;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_reg   <= IDLE;
            win_d_reg   <= 1'b0;
            len_reg     <= '0;
            start_reg   <= '0;
            rpt_len_reg <= '0;
            rpt_err_reg <= 1'b0;
            to_pend_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            win_d_reg   <= win_in;
            len_reg     <= len_next;
            start_reg   <= start_next;
            rpt_len_reg <= rpt_len_next;
            rpt_err_reg <= rpt_err_next;
            to_pend_reg <= to_pend_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        len_next     = len_reg;
        start_next   = start_reg;
        rpt_len_next = rpt_len_reg;
        rpt_err_next = rpt_err_reg;
        to_pend_next = to_pend_reg;
        drop         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (arm) begin
                    start_next = cyc_cnt;
                    len_next   = LEN_W'(1);
                    state_next = OPEN;
                end
            end
            OPEN: begin
                if (win_in) begin
                    if (len_reg < MAX_L) begin
                        len_next = len_reg + LEN_W'(1);
                    end else begin
                        // Timed out: report now, then swallow the rest of the window.
                        rpt_len_next = MAX_L;
                        rpt_err_next = 1'b1;
                        to_pend_next = 1'b1;
                        state_next   = REPORT;
                    end
                end else begin
                    rpt_len_next = len_reg;
                    rpt_err_next = (len_reg != EXP_L);
                    state_next   = REPORT;
                end
            end
            REPORT: begin
                if (rpt_ready) begin
                    if (to_pend_reg) begin
                        state_next = DRAIN;
                        drop       = arm;
                    end else if (arm) begin
                        start_next = cyc_cnt;
                        len_next   = LEN_W'(1);
                        state_next = OPEN;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    drop = arm;
                end
            end
            DRAIN: begin
                drop = arm;
                if (!win_in) begin
                    state_next   = IDLE;
                    to_pend_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            err_sticky_reg <= 1'b0;
            ovr_sticky_reg <= 1'b0;
        end else if (clr) begin
            err_sticky_reg <= 1'b0;
            ovr_sticky_reg <= 1'b0;
        end else begin
            if (hs && rpt_err_reg) err_sticky_reg <= 1'b1;
            if (drop)              ovr_sticky_reg <= 1'b1;
        end
    end

    window_monitor_sat_counter #(
        .W (NUM_W)
    ) u_win_count (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .clr   (clr),
        .inc   (hs),
        .count (win_count)
    );

    assign rpt_valid  = (state_reg == REPORT);
    assign rpt_len    = rpt_len_reg;
    assign rpt_start  = start_reg;
    assign rpt_err    = rpt_err_reg;
    assign err_sticky = err_sticky_reg;
    assign ovr_sticky = ovr_sticky_reg;

endmodule
